// File: rtl/display_scanner.sv
// ============================================================================
// display_scanner
// ----------------------------------------------------------------------------
// Time-multiplexed scan controller that sits directly upstream of the shared
// hex-to-seven-segment decoder.
//
// A packed multi-digit hex value is accepted over a valid/ready handshake into
// a shadow register. The shadow is copied into the display register only at a
// scan-frame boundary, so a frame is always drawn from one consistent value
// and the display never tears.
//
// On every clock the block presents, registered from the previous cycle's scan
// state:
//   * the 4-bit code of the selected digit and a decoder enable, and
//   * a one-hot digit select for the common-anode/cathode drivers.
//
// Parameters
//   DIGITS    number of multiplexed digits (1..8)
//   PRESCALE  clock cycles per digit slot (>= 2)
//
// Ports
//   clk         in   system clock, all state on the rising edge
//   reset       in   asynchronous, active-high reset
//   value       in   4*DIGITS packed hex digits, digit 0 in bits [3:0]
//   load_valid  in   value is offered this cycle
//   load_ready  out  shadow register is free (transfer on valid & ready)
//   num         out  hex code of the selected digit, to the decoder
//   enable      out  decoder enable, 0 blanks the segments
//   digit_sel   out  one-hot, active-high digit select
//   frame_tick  out  one-cycle pulse after each completed scan frame
//
// Build option
//   LEADING_ZERO_BLANK_EN  when defined, leading zero digits (every digit k>0
//                          whose digits k..DIGITS-1 are all zero) are blanked.
//                          Digit 0 is never blanked, so zero shows as "0".
//                          When undefined, every digit is shown.
// ============================================================================
module display_scanner #(
    parameter int DIGITS   = 4,
    parameter int PRESCALE = 50000
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [4*DIGITS-1:0]   value,
    input  logic                  load_valid,
    output logic                  load_ready,
    output logic [3:0]            num,
    output logic                  enable,
    output logic [DIGITS-1:0]     digit_sel,
    output logic                  frame_tick
);

    // ------------------------------------------------------------------------
    // Widths and terminal counts
    // ------------------------------------------------------------------------
    localparam int CNT_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(PRESCALE - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DIGITS - 1);

    // ------------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------------
    logic [CNT_W-1:0]    cnt_q,      cnt_d;
    logic [IDX_W-1:0]    idx_q,      idx_d;
    logic [4*DIGITS-1:0] disp_q,     disp_d;
    logic [4*DIGITS-1:0] shadow_q,   shadow_d;
    logic                pending_q,  pending_d;

    // Output registers
    logic [3:0]          num_q,        num_d;
    logic                enable_q,     enable_d;
    logic [DIGITS-1:0]   digit_sel_q,  digit_sel_d;
    logic                frame_tick_q, frame_tick_d;

    // ------------------------------------------------------------------------
    // Combinational helpers
    // ------------------------------------------------------------------------
    logic                cnt_wrap;
    logic                boundary;
    logic                xfer;
    logic                commit;
    logic                blank_cur;

    logic [3:0]          digit_w [DIGITS];
    logic [DIGITS-1:0]   blank_w;

    // Split the display register into individual hex digits.
    generate
        for (genvar gi = 0; gi < DIGITS; gi++) begin : g_digit
            assign digit_w[gi] = disp_q[4*gi +: 4];
        end
    endgenerate

    // Per-digit blanking. A digit k>0 is a leading zero when it and every
    // more significant digit are zero. Digit 0 always shows.
`ifdef LEADING_ZERO_BLANK_EN
    generate
        for (genvar gi = 0; gi < DIGITS; gi++) begin : g_blank
            if (gi == 0) begin : g_lsd
                assign blank_w[gi] = 1'b0;
            end else begin : g_upper
                assign blank_w[gi] = (disp_q[4*DIGITS-1 : 4*gi] == '0);
            end
        end
    endgenerate
`else
    assign blank_w = '0;
`endif

    // ------------------------------------------------------------------------
    // Next-state and next-output logic
    // ------------------------------------------------------------------------
    always_comb begin
        // Scan position
        cnt_wrap = (cnt_q == CNT_LAST);
        boundary = cnt_wrap && (idx_q == IDX_LAST);

        // A transfer can only happen while the shadow is free, and a commit
        // only while it is occupied, so the two never coincide.
        xfer     = load_valid && !pending_q;
        commit   = boundary && pending_q;

        // Prescale counter and digit index
        cnt_d = cnt_wrap ? '0 : cnt_q + CNT_W'(1);
        idx_d = idx_q;
        if (cnt_wrap) begin
            idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + IDX_W'(1);
        end

        // Shadow / display / pending handshake
        shadow_d  = shadow_q;
        disp_d    = disp_q;
        pending_d = pending_q;
        if (commit) begin
            disp_d    = shadow_q;
            pending_d = 1'b0;
        end else if (xfer) begin
            shadow_d  = value;
            pending_d = 1'b1;
        end

        // Digit mux and one-hot select for the current index
        num_d       = '0;
        digit_sel_d = '0;
        blank_cur   = 1'b0;
        for (int k = 0; k < DIGITS; k++) begin
            if (idx_q == IDX_W'(k)) begin
                num_d          = digit_w[k];
                digit_sel_d[k] = 1'b1;
                blank_cur      = blank_w[k];
            end
        end

        // The first cycle of every slot is dark so the previous digit's
        // segments never ghost onto the newly selected driver.
        enable_d     = (cnt_q != '0) && !blank_cur;
        frame_tick_d = boundary;
    end

    // ------------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q        <= '0;
            idx_q        <= '0;
            disp_q       <= '0;
            shadow_q     <= '0;
            pending_q    <= 1'b0;
            num_q        <= '0;
            enable_q     <= 1'b0;
            digit_sel_q  <= '0;
            frame_tick_q <= 1'b0;
        end else begin
            cnt_q        <= cnt_d;
            idx_q        <= idx_d;
            disp_q       <= disp_d;
            shadow_q     <= shadow_d;
            pending_q    <= pending_d;
            num_q        <= num_d;
            enable_q     <= enable_d;
            digit_sel_q  <= digit_sel_d;
            frame_tick_q <= frame_tick_d;
        end
    end

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    // Ready comes straight from the pending flop, so it is glitch-free and
    // reads 1 while reset is held.
    assign load_ready = ~pending_q;
    assign num        = num_q;
    assign enable     = enable_q;
    assign digit_sel  = digit_sel_q;
    assign frame_tick = frame_tick_q;

endmodule

// File: tb/tb_display_scanner.sv
// ============================================================================
// tb_display_scanner
// ----------------------------------------------------------------------------
// Scoreboard bench for display_scanner with DIGITS=4, PRESCALE=4.
// The driver issues stimulus one cycle at a time. For each cycle it computes
// the expected outputs from a cycle-count reference model and pushes them into
// a queue. A separate monitor pops the queue on the falling edge and compares.
// ============================================================================
module tb_display_scanner;

    localparam int D     = 4;
    localparam int P     = 4;
    localparam int FRAME = D * P;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [15:0]   value = '0;
    logic          load_valid = 1'b0;
    logic          load_ready;
    logic [3:0]    num;
    logic          enable;
    logic [3:0]    digit_sel;
    logic          frame_tick;

    display_scanner #(
        .DIGITS   (D),
        .PRESCALE (P)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .value      (value),
        .load_valid (load_valid),
        .load_ready (load_ready),
        .num        (num),
        .enable     (enable),
        .digit_sel  (digit_sel),
        .frame_tick (frame_tick)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int         tgt;
        logic [3:0] num;
        logic       en;
        logic [3:0] sel;
        logic       tick;
        logic       rdy;
    } exp_t;

    exp_t exp_q[$];

    int checks = 0;
    int errors = 0;

    // Reference model: position in the scan is derived purely from the number
    // of cycles since reset release.
    int          n;
    bit          pend_m;
    logic [15:0] shadow_m;
    logic [15:0] disp_m;

    function automatic bit blank_m(input int k, input logic [15:0] d);
        bit lz = 1'b0;
`ifdef LEADING_ZERO_BLANK_EN
        lz = 1'b1;
`endif
        return lz && (k > 0) && ((d >> (4 * k)) == 16'h0);
    endfunction

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s cycle %0d: got %0h expected %0h", name, cyc, act, req);
        end
    endtask

    // Called at 1 time unit after a rising edge (or at reset release). Drives
    // inputs for the next edge and records what the outputs must be after it.
    task automatic step(input bit lv, input logic [15:0] v);
        exp_t e;
        int   cntm;
        int   idxm;
        bit   bnd;
        load_valid = lv;
        value      = v;
        cntm = n % P;
        idxm = (n / P) % D;
        bnd  = ((n % FRAME) == FRAME - 1);
        e.tgt  = cyc + 1;
        e.num  = 4'((disp_m >> (4 * idxm)) & 16'hF);
        e.sel  = 4'(1 << idxm);
        e.en   = (cntm != 0) && !blank_m(idxm, disp_m);
        e.tick = bnd;
        if (bnd && pend_m) begin
            disp_m = shadow_m;
            pend_m = 1'b0;
            $display("commit value=%h at cycle %0d", disp_m, cyc + 1);
        end else if (lv && !pend_m) begin
            shadow_m = v;
            pend_m   = 1'b1;
            $display("load value=%h at cycle %0d (frame phase %0d)", v, cyc + 1, n % FRAME);
        end
        e.rdy = !pend_m;
        n++;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    // Asserted just after a rising edge, so an asynchronous reset must show
    // on the outputs well before the next edge.
    task automatic do_reset();
        reset      = 1'b1;
        load_valid = 1'b0;
        exp_q.delete();
        n        = 0;
        pend_m   = 1'b0;
        shadow_m = '0;
        disp_m   = '0;
        $display("reset asserted at cycle %0d", cyc);
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        reset = 1'b0;
        $display("reset released at cycle %0d", cyc);
    endtask

    task automatic idle_until(input int phase);
        for (int i = 0; i < FRAME; i++) begin
            if ((n % FRAME) == phase) break;
            step(1'b0, 16'h0);
        end
    endtask

    // ------------------------------------------------------------------------
    // Monitor
    // ------------------------------------------------------------------------
    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (reset) begin
                chk("rst_num",        num,        0);
                chk("rst_enable",     enable,     0);
                chk("rst_digit_sel",  digit_sel,  0);
                chk("rst_frame_tick", frame_tick, 0);
                chk("rst_load_ready", load_ready, 1);
            end else if (exp_q.size() > 0 && exp_q[0].tgt == cyc) begin
                e = exp_q.pop_front();
                chk("num",        num,        e.num);
                chk("enable",     enable,     e.en);
                chk("digit_sel",  digit_sel,  e.sel);
                chk("frame_tick", frame_tick, e.tick);
                chk("load_ready", load_ready, e.rdy);
            end
        end
    end

    // ------------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------------
    initial begin : driver
        @(posedge clk);
        #1;
        do_reset();

        // Free-running scan of an all-zero display
        repeat (40) step(1'b0, 16'h0);

        // Load mid-frame, then offer another value while it is pending
        idle_until(5);
        step(1'b1, 16'h1A2F);
        for (int i = 0; i < 64 && pend_m; i++) step(1'b1, 16'hBEEF);
        repeat (3) step(1'b0, 16'h0);
        step(1'b1, 16'hBEEF);
        repeat (40) step(1'b0, 16'h0);

        // Transfer on the boundary cycle itself
        idle_until(FRAME - 1);
        step(1'b1, 16'h0005);
        repeat (40) step(1'b0, 16'h0);

        // Leading-zero patterns
        idle_until(2);
        step(1'b1, 16'h0000);
        repeat (40) step(1'b0, 16'h0);
        idle_until(2);
        step(1'b1, 16'h0100);
        repeat (40) step(1'b0, 16'h0);

        // Reset while a transfer is waiting for its boundary
        idle_until(3);
        step(1'b1, 16'h1234);
        repeat (4) step(1'b0, 16'h0);
        do_reset();
        repeat (40) step(1'b0, 16'h0);

        // Randomized traffic
        for (int i = 0; i < 800; i++) begin
            step(($urandom_range(0, 7) == 0), 16'($urandom));
        end

        // Every expectation must have been consumed by the monitor
        @(negedge clk);
        #1;
        chk("scoreboard_drained", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
